accel_stream_arbiter: RTL and testbench
=======================================

// Module: accel_stream_arbiter
// PURPOSE
//  Shares the single AXI-Stream input of the HLS accelerator between NUM_SRC buffered
//  sources (fifo-to-stream bridges). Round-robin, packet-granular: a granted source owns the
//  port until its tlast beat is accepted. Pulses accel_start per packet, tags beats with source
//  id, and guards against stalled or oversized packets with a watchdog and a beat-count limit.
// PARAMETERS
//  NUM_SRC     4    number of requesting sources (2..8)
//  DATA_WIDTH  32   stream data width
//  MAX_BEATS   16   max beats per packet; beat MAX_BEATS is forced to tlast
//  TIMEOUT     64   idle cycles in STREAM (no accepted beat) before abort
// PORTS
//  clk            in   1                      clock, all logic on rising edge
//  rst            in   1                      synchronous reset, active-high
//  src_req        in   NUM_SRC                source i has a packet ready
//  src_tdata      in   NUM_SRC*DATA_WIDTH     source i data, bits [i*DW +: DW]
//  src_tvalid     in   NUM_SRC                source i beat valid
//  src_tlast      in   NUM_SRC                source i last beat
//  src_tready     out  NUM_SRC                ready back to source i (granted source only)
//  src_grant      out  NUM_SRC                one-hot grant, registered
//  m_axis_tdata   out  DATA_WIDTH             to accelerator
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1
//  m_axis_tid     out  $clog2(NUM_SRC)        index of granted source
//  accel_start    out  1                      one-cycle pulse at start of each packet
//  err_flags      out  NUM_SRC                sticky per-source: timeout or beat overrun
//  err_clear      in   1                      clears err_flags (wins over same-cycle set)
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, wdog=0,
//    err_flags=0, accel_start=0; m_axis_tvalid=0, src_tready=0, m_axis_tlast=0, tid=0,
//    tdata=0. Reset mid-packet drops the packet; no tlast is emitted.
//  - FSM: IDLE -> GRANT -> STREAM -> IDLE; STREAM -> ABORT -> IDLE.
//  - IDLE: if any src_req, winner = first set bit scanning from rr_ptr upward with wrap;
//    register grant/tid; go GRANT. No req: stay, outputs idle.
//  - GRANT (1 cycle): accel_start=1; beat_cnt=0, wdog=0; go STREAM. Latency req->first
//    possible beat = 2 cycles.
//  - STREAM: combinational passthrough of granted source: m_axis_tdata/tvalid = src[g],
//    src_tready[g] = m_axis_tready; all other src_tready=0. Beat accepted when
//    m_axis_tvalid & m_axis_tready. m_axis_tlast = src_tlast[g] | (beat_cnt==MAX_BEATS-1).
//    Accepted beat: beat_cnt++, wdog=0. Accepted beat with m_axis_tlast: grant released,
//    rr_ptr = g+1 (wrap at NUM_SRC), go IDLE. If forced (src_tlast=0), set err_flags[g].
//    No accepted beat: wdog++; wdog==TIMEOUT-1 -> go ABORT.
//  - ABORT (1 cycle): set err_flags[g], tready/tvalid=0, rr_ptr=g+1, go IDLE. No tlast sent.
//  - src_req deassert during STREAM is ignored; only tlast/limit/timeout end a packet.
//  - Fairness: source granted last has lowest priority next arbitration; a source that
//    requests continuously is re-granted only after all other requesters are served.
//  - err_clear and set in the same cycle: clear wins. m_axis_tvalid never asserted outside
//    STREAM. beat_cnt width $clog2(MAX_BEATS)+1, wdog width $clog2(TIMEOUT)+1, no wrap.
// TESTING
//  1 Single source: req[0], 4 beats 0xA0..0xA3, tlast on 4th, tready=1 -> accel_start one
//    cycle after req, 4 beats out tid=0, tlast on 0xA3, back to IDLE, rr_ptr=1.
//  2 All 4 req held, each 2-beat packet -> grant order 0,1,2,3,0; never two grants at once.
//  3 Backpressure: m_axis_tready toggles 1,0,1,0 during src1 packet -> src_tready[1] mirrors
//    it, data stable while stalled, no beat lost/duplicated.
//  4 Overrun: src2 sends 20 beats no tlast, MAX_BEATS=16 -> beat 16 has m_axis_tlast=1,
//    err_flags=0b0100, next packet granted to src3.
//  5 Timeout: src1 granted, tvalid stays 0 for 64 cycles -> ABORT, err_flags[1]=1, IDLE;
//    err_clear pulse -> err_flags=0.
//  6 rst=1 mid-beat 3 of a packet -> next cycle all outputs at reset values, rr_ptr=0.

Source files
------------

// File: rtl/accel_stream_arbiter_if.sv
// accel_stream_arbiter_if: source streams, accelerator stream and status of the stream arbiter
interface accel_stream_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]            src_req;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_SRC-1:0]            src_tvalid;
    logic [NUM_SRC-1:0]            src_tlast;
    logic [NUM_SRC-1:0]            src_tready;
    logic [NUM_SRC-1:0]            src_grant;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [$clog2(NUM_SRC)-1:0]    m_axis_tid;
    logic                          accel_start;
    logic [NUM_SRC-1:0]            err_flags;
    logic                          err_clear;
    modport master (
        input  src_req, src_tdata, src_tvalid, src_tlast, m_axis_tready, err_clear,
        output src_tready, src_grant, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
               accel_start, err_flags
    );
    modport slave (
        output src_req, src_tdata, src_tvalid, src_tlast, m_axis_tready, err_clear,
        input  src_tready, src_grant, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
               accel_start, err_flags
    );
endinterface

// File: rtl/accel_stream_arbiter.sv
// accel_stream_arbiter: packet-granular round-robin sharing of one AXI-Stream port,
// with per-packet start pulse, source tagging, beat limit and stall watchdog.
module accel_stream_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int TIMEOUT    = 64
) (
    input logic                 clk,
    input logic                 rst,
    accel_stream_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, ABORT} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d, tid_q, tid_d, winner, next_ptr;
    logic [NUM_SRC-1:0] grant_q, grant_d, err_flags_q, err_flags_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic               accel_start_q, accel_start_d;
    logic               streaming, valid, beat, last;
    logic [DATA_WIDTH-1:0] tdata;

    // Scanning downward leaves the first requester at or after ptr as the winner.
    function automatic logic [IW-1:0] pick(input logic [NUM_SRC-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] idx;
        pick = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            idx = idx >= (IW+1)'(NUM_SRC) ? idx - (IW+1)'(NUM_SRC) : idx;
            pick = req[idx[IW-1:0]] ? idx[IW-1:0] : pick;
        end
    endfunction

    always_comb begin
        tdata = '0;
        for (int i = 0; i < NUM_SRC; i++)
            tdata = tid_q == IW'(i) ? bus.src_tdata[i*DATA_WIDTH +: DATA_WIDTH] : tdata;
    end

    assign winner    = pick(bus.src_req, rr_ptr_q);
    assign next_ptr  = tid_q == IW'(NUM_SRC - 1) ? '0 : tid_q + 1'b1;
    assign streaming = state_q == STREAM;
    assign valid     = streaming & bus.src_tvalid[tid_q];
    assign beat      = valid & bus.m_axis_tready;
    assign last      = bus.src_tlast[tid_q] | (beat_cnt_q == BW'(MAX_BEATS - 1));

    assign bus.m_axis_tdata  = streaming ? tdata : '0;
    assign bus.m_axis_tvalid = valid;
    assign bus.m_axis_tlast  = streaming & last;
    assign bus.m_axis_tid    = tid_q;
    assign bus.src_tready    = streaming && bus.m_axis_tready ? grant_q : '0;
    assign bus.src_grant     = grant_q;
    assign bus.accel_start   = accel_start_q;
    assign bus.err_flags     = err_flags_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tid_d         = tid_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        wdog_d        = wdog_q;
        err_flags_d   = err_flags_q;
        accel_start_d = 1'b0;
        if (state_q == IDLE && |bus.src_req) begin
            state_d       = GRANT;
            tid_d         = winner;
            grant_d       = NUM_SRC'(1) << winner;
            accel_start_d = 1'b1;
        end
        if (state_q == GRANT) begin
            state_d    = STREAM;
            beat_cnt_d = '0;
            wdog_d     = '0;
        end
        if (beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            wdog_d     = '0;
            state_d    = last ? IDLE : state_d;
            grant_d    = last ? '0 : grant_d;
            rr_ptr_d   = last ? next_ptr : rr_ptr_d;
            err_flags_d = last && !bus.src_tlast[tid_q] ? err_flags_q | grant_q : err_flags_d;
        end
        if (streaming && !beat) begin
            wdog_d  = wdog_q + 1'b1;
            state_d = wdog_q == WW'(TIMEOUT - 1) ? ABORT : state_d;
        end
        if (state_q == ABORT) begin
            state_d     = IDLE;
            err_flags_d = err_flags_q | grant_q;
            grant_d     = '0;
            rr_ptr_d    = next_ptr;
        end
        err_flags_d = bus.err_clear ? '0 : err_flags_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            tid_q         <= '0;
            grant_q       <= '0;
            beat_cnt_q    <= '0;
            wdog_q        <= '0;
            err_flags_q   <= '0;
            accel_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tid_q         <= tid_d;
            grant_q       <= grant_d;
            beat_cnt_q    <= beat_cnt_d;
            wdog_q        <= wdog_d;
            err_flags_q   <= err_flags_d;
            accel_start_q <= accel_start_d;
        end
    end
endmodule

// File: tb/tb_accel_stream_arbiter.sv
// tb_accel_stream_arbiter: queue-fed sources, per-source expected-beat scoreboard and
// expected grant order for the stream arbiter.
module tb_accel_stream_arbiter;
    localparam int NS = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    accel_stream_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

    accel_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BEATS(16), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    beat_t         src_q[NS][$];
    beat_t         exp_q[NS][$];
    int            exp_order[$];
    logic [NS-1:0] force_req;
    int            errors = 0;
    int            checks = 0;
    int            grant_cycles = 0;
    bit            rdy_toggle = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW+1:0] prev_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.src_req[i]            = src_q[i].size() > 0 || force_req[i];
            bus.src_tvalid[i]         = src_q[i].size() > 0;
            bus.src_tdata[i*DW +: DW] = src_q[i].size() > 0 ? src_q[i][0].data : '0;
            bus.src_tlast[i]          = src_q[i].size() > 0 && src_q[i][0].last;
        end
        bus.m_axis_tready = rdy_toggle ? ~bus.m_axis_tready : 1'b1;
    endtask

    // Observe at the falling edge; a beat seen valid&ready here is taken at the next rising edge.
    task automatic tick();
        int    s;
        beat_t b;
        @(negedge clk);
        s = int'(bus.m_axis_tid);
        chk("grant_onehot", 64'($countones(bus.src_grant) <= 1), 64'(1));
        if (bus.src_grant != '0) grant_cycles++;
        if (bus.accel_start) begin
            chk("start_tid", 64'(bus.src_grant), 64'(NS'(1) << bus.m_axis_tid));
            chk("grant_expected", 64'(exp_order.size() > 0), 64'(1));
            if (exp_order.size() > 0) chk("grant_order", 64'(s), 64'(exp_order.pop_front()));
            force_req = '0;
        end
        if (bus.src_grant == '0)
            chk("idle_quiet", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.src_tready}), 64'(0));
        if (bus.m_axis_tvalid)
            chk("tready_mirror", 64'(bus.src_tready), 64'(bus.m_axis_tready ? bus.src_grant : '0));
        if (prev_stall)
            chk("stall_hold", 64'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid}), 64'({1'b1, prev_out}));
        prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready && !rst;
        prev_out   = {bus.m_axis_tdata, bus.m_axis_tid};
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            chk("beat_expected", 64'(exp_q[s].size() > 0), 64'(1));
            if (exp_q[s].size() > 0) begin
                b = exp_q[s].pop_front();
                chk("beat", 64'({bus.m_axis_tdata, bus.m_axis_tlast}), 64'(b));
            end
            if (src_q[s].size() > 0) void'(src_q[s].pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    // One packet per call; the expected copy is cut at beat 16 with tlast forced there.
    task automatic load(input int s, input int n, input logic [DW-1:0] base, input int last_at);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + DW'(k);
            b.last = k == last_at;
            src_q[s].push_back(b);
            b.last = k == last_at || k == 15;
            if (k < 16) exp_q[s].push_back(b);
        end
    endtask

    function automatic bit busy();
        busy = exp_order.size() > 0;
        for (int i = 0; i < NS; i++) busy |= exp_q[i].size() > 0;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        while (n < budget && (busy() || bus.src_grant != '0)) begin
            tick();
            n++;
        end
        chk("run_done", 64'(n < budget), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        exp_order.delete();
        drive();
        tick();
        chk("rst_outputs", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tdata,
                               bus.src_grant, bus.src_tready, bus.accel_start, bus.err_flags}), 64'(0));
        rst = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic clear_errs();
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        chk("err_cleared", 64'(bus.err_flags), 64'(0));
    endtask

    initial begin
        int n;
        force_req         = '0;
        bus.m_axis_tready = 1'b1;
        bus.err_clear     = 1'b0;
        do_reset();
        // Single source: start pulse one cycle after request, four beats, tlast on 0xA3
        load(0, 4, 32'hA0, 3);
        exp_order.push_back(0);
        grant_cycles = 0;
        drive();
        chk("t1_start_pre", 64'(bus.accel_start), 64'(0));
        tick();
        chk("t1_start", 64'({bus.accel_start, bus.src_grant}), 64'({1'b1, 4'b0001}));
        run(50);
        chk("t1_grant_cycles", 64'(grant_cycles), 64'(5));
        chk("t1_errs", 64'(bus.err_flags), 64'(0));
        // Pointer moved past source 0: source 1 wins the tie
        load(0, 2, 32'hB0, 1);
        load(1, 1, 32'hC0, 0);
        exp_order.push_back(1);
        exp_order.push_back(0);
        drive();
        run(50);
        // All four requesting
        do_reset();
        load(0, 2, 32'h100, 1);
        load(0, 2, 32'h110, 1);
        load(1, 2, 32'h200, 1);
        load(2, 2, 32'h300, 1);
        load(3, 2, 32'h400, 1);
        foreach (exp_order[i]) exp_order.delete(i);
        exp_order = '{0, 1, 2, 3, 0};
        drive();
        run(100);
        // Backpressure on source 1
        rdy_toggle = 1'b1;
        load(1, 4, 32'h500, 3);
        exp_order.push_back(1);
        drive();
        run(100);
        rdy_toggle = 1'b0;
        // Overrun on source 2, source 3 follows
        load(2, 20, 32'h600, -1);
        load(3, 2, 32'h700, 1);
        exp_order = '{2, 3};
        drive();
        n = 0;
        while (n < 100 && exp_q[2].size() > 0) begin
            tick();
            n++;
        end
        chk("t4_forced_done", 64'(n < 100), 64'(1));
        src_q[2].delete();
        drive();
        run(100);
        chk("t4_err", 64'(bus.err_flags), 64'(4'b0100));
        clear_errs();
        // Watchdog on source 1
        force_req[1] = 1'b1;
        exp_order.push_back(1);
        grant_cycles = 0;
        drive();
        run(200);
        chk("t5_grant_cycles", 64'(grant_cycles), 64'(66));
        chk("t5_err", 64'(bus.err_flags), 64'(4'b0010));
        clear_errs();
        // Reset while the third beat is presented
        load(2, 5, 32'h800, 4);
        exp_order.push_back(2);
        drive();
        n = 0;
        while (n < 50 && exp_q[2].size() > 3) begin
            tick();
            n++;
        end
        chk("t6_two_beats", 64'(n < 50), 64'(1));
        chk("t6_mid_packet", 64'({bus.m_axis_tvalid, bus.m_axis_tid}), 64'({1'b1, 2'd2}));
        do_reset();
        load(1, 1, 32'h900, 0);
        load(3, 1, 32'hA00, 0);
        exp_order = '{1, 3};
        drive();
        run(50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
